// File: rtl/rv32e_mem_pkg.sv
// Shared types and constants for the rv32e SPI memory controller.
package rv32e_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    localparam logic [7:0]  CMD_READ_DEF  = 8'h03;
    localparam logic [7:0]  CMD_WRITE_DEF = 8'h02;
    localparam int unsigned RAM_SEL_BIT   = 23;
    localparam int unsigned FRAME_W       = 64;
    localparam int unsigned CNT_W         = 6;

    // Index of the final bit of a frame: 8 opcode + 24 address + data bits, minus one.
    function automatic logic [CNT_W-1:0] frame_last_idx(input size_e sz);
        case (sz)
            SZ_BYTE: frame_last_idx = CNT_W'(39);
            SZ_HALF: frame_last_idx = CNT_W'(47);
            default: frame_last_idx = CNT_W'(63);
        endcase
    endfunction

    // First received byte sits highest in the shift window; place it in the low lane.
    function automatic logic [31:0] order_rdata(input size_e sz, input logic [31:0] rx);
        case (sz)
            SZ_BYTE: order_rdata = {24'h0, rx[7:0]};
            SZ_HALF: order_rdata = {16'h0, rx[7:0], rx[15:8]};
            default: order_rdata = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        endcase
    endfunction

endpackage

// File: rtl/spi_mem_shifter.sv
// Two-phase SPI mode-0 bit engine: each bit is one low clk (MOSI update) and one high clk
// (MISO sampled at its end).
module spi_mem_shifter
    import rv32e_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [CNT_W-1:0]   last_idx_i,
    output logic               busy_o,
    output logic               last_c_o,
    output logic               sck_o,
    output logic               mosi_o,
    input  logic               miso_i,
    output logic [31:0]        rx_c_o
);

    logic [FRAME_W-2:0] sr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [30:0]        rx_q;
    logic               busy_q;
    logic               sck_q;
    logic               mosi_q;

    // High phase of the final bit: the FSM leaves SHIFT on this edge.
    assign last_c_o = busy_q && sck_q && (cnt_q == '0);
    assign rx_c_o   = {rx_q, miso_i};
    assign busy_o   = busy_q;
    assign sck_o    = sck_q;
    assign mosi_o   = mosi_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            rx_q   <= '0;
            busy_q <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
        end else if (load_i) begin
            sr_q   <= frame_i[FRAME_W-2:0];
            mosi_q <= frame_i[FRAME_W-1];
            cnt_q  <= last_idx_i;
            sck_q  <= 1'b0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            if (!sck_q) begin
                sck_q <= 1'b1;
            end else begin
                sck_q <= 1'b0;
                rx_q  <= rx_c_o[30:0];
                if (cnt_q == '0) begin
                    busy_q <= 1'b0;
                    mosi_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_q - CNT_W'(1);
                    mosi_q <= sr_q[FRAME_W-2];
                    sr_q   <= {sr_q[FRAME_W-3:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI memory controller: one CPU load/store/fetch request becomes one SPI read/write
// transaction on the flash (code) or RAM (data) device.
module spi_mem_ctrl
    import rv32e_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = RAM_SEL_BIT + 1,
    parameter logic [7:0]  CMD_READ  = CMD_READ_DEF,
    parameter logic [7:0]  CMD_WRITE = CMD_WRITE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_cs_flash_n,
    output logic              spi_cs_ram_n
);

    localparam int unsigned RAM_BIT = ADDR_W - 1;

    state_e      state_q, state_d;
    size_e       size_q, size_d;
    logic        we_q, we_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cs_flash_n_q, cs_flash_n_d;
    logic        cs_ram_n_q, cs_ram_n_d;
    logic [31:0] rdata_q, rdata_d;

    size_e              sz_c;
    logic               illegal_c;
    logic               load_c;
    logic [FRAME_W-1:0] frame_c;
    logic               busy;
    logic               last_c;
    logic [31:0]        rx_c;

    assign sz_c      = size_e'(size);
    assign illegal_c = (sz_c == SZ_ILLEGAL) || (we && !addr[RAM_BIT]);

    // Opcode, device address with the select bit cleared, then data bytes lowest lane first.
    assign frame_c = {we ? CMD_WRITE : CMD_READ,
                      24'({1'b0, addr[ADDR_W-2:0]}),
                      we ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} : 32'h0};

    spi_mem_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_c),
        .frame_i    (frame_c),
        .last_idx_i (frame_last_idx(sz_c)),
        .busy_o     (busy),
        .last_c_o   (last_c),
        .sck_o      (spi_sck),
        .mosi_o     (spi_mosi),
        .miso_i     (spi_miso),
        .rx_c_o     (rx_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            size_q       <= SZ_BYTE;
            we_q         <= 1'b0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            cs_flash_n_q <= 1'b1;
            cs_ram_n_q   <= 1'b1;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            we_q         <= we_d;
            ready_q      <= ready_d;
            done_q       <= done_d;
            err_q        <= err_d;
            cs_flash_n_q <= cs_flash_n_d;
            cs_ram_n_q   <= cs_ram_n_d;
            rdata_q      <= rdata_d;
        end
    end

    // DONE also accepts, so a held request restarts with exactly one CS-high cycle between frames.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        we_d         = we_q;
        ready_d      = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        cs_flash_n_d = cs_flash_n_q;
        cs_ram_n_d   = cs_ram_n_q;
        rdata_d      = rdata_q;
        load_c       = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d      = ST_IDLE;
                ready_d      = 1'b1;
                cs_flash_n_d = 1'b1;
                cs_ram_n_d   = 1'b1;
                if (req && !busy) begin
                    ready_d = 1'b0;
                    we_d    = we;
                    size_d  = sz_c;
                    rdata_d = '0;
                    if (illegal_c) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d      = ST_SHIFT;
                        load_c       = 1'b1;
                        cs_flash_n_d = addr[RAM_BIT];
                        cs_ram_n_d   = !addr[RAM_BIT];
                    end
                end
            end
            ST_SHIFT: begin
                if (last_c) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    cs_flash_n_d = 1'b1;
                    cs_ram_n_d   = 1'b1;
                    rdata_d      = we_q ? 32'h0 : order_rdata(size_q, rx_c);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready          = ready_q;
    assign done           = done_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign spi_cs_flash_n = cs_flash_n_q;
    assign spi_cs_ram_n   = cs_ram_n_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Randomized bench for spi_mem_ctrl with behavioural SPI flash/RAM models and a scoreboard.
module tb_spi_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_flash_n;
    logic        spi_cs_ram_n;

    int checks = 0;
    int fails  = 0;
    int proto  = 0;
    int cs_falls = 0;
    int sck_rises = 0;
    int fall0 = 0;
    int rise0 = 0;
    bit sel_ram = 0;
    logic mosi_bits[$];
    logic [7:0] flash_mem [int];
    logic [7:0] ram_mem [int];
    logic prev_mosi = 1'b0;
    logic [1:0] prev_cs = 2'b11;

    spi_mem_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .we             (we),
        .size           (size),
        .addr           (addr),
        .wdata          (wdata),
        .ready          (ready),
        .done           (done),
        .err            (err),
        .rdata          (rdata),
        .spi_sck        (spi_sck),
        .spi_mosi       (spi_mosi),
        .spi_miso       (spi_miso),
        .spi_cs_flash_n (spi_cs_flash_n),
        .spi_cs_ram_n   (spi_cs_ram_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_rd(input bit ram, input int a);
        if (ram) return ram_mem.exists(a) ? ram_mem[a] : 8'((a * 13 + 5) & 255);
        return flash_mem.exists(a) ? flash_mem[a] : 8'(((a * 7 + 1) ^ 32'h5A) & 255);
    endfunction

    function automatic int dev_addr(input logic [23:0] a, input int off);
        return (int'(a[22:0]) + off) & 32'h7FFFFF;
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] bits_val(input int s, input int len);
        logic [31:0] r = '0;
        for (int i = 0; i < len; i++)
            r = {r[30:0], (s + i < mosi_bits.size()) ? mosi_bits[s + i] : 1'b0};
        return r;
    endfunction

    // Little-endian value the memory model holds at addr for the given size.
    function automatic logic [31:0] exp_read(input logic [23:0] a, input logic [1:0] s);
        logic [31:0] r = '0;
        for (int i = 0; i < nbytes(s); i++)
            r[8*i +: 8] = mem_rd(a[23], dev_addr(a, i));
        return r;
    endfunction

    // Slave side: frame capture on CS fall / SCK rise, MISO driven on SCK fall (mode 0).
    always @(negedge spi_cs_flash_n or negedge spi_cs_ram_n) begin
        mosi_bits.delete();
        sel_ram = !spi_cs_ram_n;
        cs_falls++;
    end

    always @(posedge spi_sck) begin
        if (spi_cs_flash_n == spi_cs_ram_n) proto++;
        mosi_bits.push_back(spi_mosi);
        sck_rises++;
    end

    always @(negedge spi_sck) begin
        int n, d, a;
        logic [7:0] b;
        n = mosi_bits.size();
        spi_miso = 1'b0;
        if (n >= 32) begin
            a = int'(bits_val(8, 24));
            d = n - 32;
            if (bits_val(0, 8) == 32'h03) begin
                b = mem_rd(sel_ram, (a + d / 8) & 32'h7FFFFF);
                spi_miso = b[7 - (d % 8)];
            end else if (bits_val(0, 8) == 32'h02 && sel_ram && d > 0 && (d % 8) == 0) begin
                ram_mem[(a + d / 8 - 1) & 32'h7FFFFF] = 8'(bits_val(n - 8, 8));
            end
        end
    end

    // Protocol watch: one CS at most, CS moves only with SCK low, MOSI stable across a bit.
    always @(negedge clk) begin
        if (!spi_cs_flash_n && !spi_cs_ram_n) proto++;
        if (rst_n && ({spi_cs_flash_n, spi_cs_ram_n} != prev_cs) && spi_sck) proto++;
        if (rst_n && spi_sck && (spi_mosi !== prev_mosi)) proto++;
        prev_cs   = {spi_cs_flash_n, spi_cs_ram_n};
        prev_mosi = spi_mosi;
    end

    // Called right after the acceptance edge; returns at the negedge where done is seen.
    task automatic finish_txn(input logic t_we, input logic [1:0] t_size, input logic [23:0] t_addr,
                              input logic [31:0] t_wdata, input logic [31:0] exp_rd, input bit chain,
                              input logic [1:0] n_size, input logic [23:0] n_addr);
        int nb, k, exp_n;
        bit ill;
        logic [31:0] ew;
        nb    = nbytes(t_size);
        ill   = (t_size == 2'd3) || (t_we && !t_addr[23]);
        exp_n = 32 + 8 * nb;
        k     = 0;
        @(negedge clk);
        if (!chain) req = 1'b0;
        if (!ill) begin
            check("cs_sel", t_addr[23] ? spi_cs_ram_n : spi_cs_flash_n, 0);
            check("cs_other", t_addr[23] ? spi_cs_flash_n : spi_cs_ram_n, 1);
        end
        while (!done && k < 400) begin
            if (chain) begin
                req   = 1'($urandom);
                we    = 1'($urandom);
                size  = 2'($urandom);
                addr  = 24'($urandom);
            end
            if (ready) proto++;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        if (chain) begin
            req = 1'b1; we = 1'b0; size = n_size; addr = n_addr;
        end
        check("latency", k, ill ? 0 : 2 * exp_n);
        check("done", done, 1);
        check("err", err, ill);
        check("ready_in_done", ready, 0);
        check("cs_idle", {spi_cs_flash_n, spi_cs_ram_n}, 2'b11);
        check("sck_idle", spi_sck, 0);
        if (ill) begin
            check("no_cs", cs_falls - fall0, 0);
            check("no_sck", sck_rises - rise0, 0);
        end else begin
            check("nbits", mosi_bits.size(), exp_n);
            check("cs_falls", cs_falls - fall0, 1);
            check("opcode", bits_val(0, 8), t_we ? 32'h02 : 32'h03);
            check("maddr", bits_val(8, 24), {9'h0, t_addr[22:0]});
            if (t_we) begin
                ew = '0;
                for (int i = 0; i < nb; i++) ew = {ew[23:0], t_wdata[8*i +: 8]};
                check("wbits", bits_val(32, 8 * nb), ew);
                for (int i = 0; i < nb; i++)
                    check("wmem", mem_rd(1'b1, dev_addr(t_addr, i)), t_wdata[8*i +: 8]);
            end else begin
                check("rd_mosi0", bits_val(32, 8 * nb), 0);
                check("rdata", rdata, exp_rd);
            end
        end
        fall0 = cs_falls;
        rise0 = sck_rises;
    endtask

    task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic [23:0] t_addr,
                           input logic [31:0] t_wdata, input logic [31:0] exp_rd);
        int w = 0;
        @(negedge clk);
        while (!ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("ready_wait", ready, 1);
        req = 1'b1; we = t_we; size = t_size; addr = t_addr; wdata = t_wdata;
        fall0 = cs_falls;
        rise0 = sck_rises;
        @(posedge clk);
        finish_txn(t_we, t_size, t_addr, t_wdata, exp_rd, 1'b0, 2'd0, 24'h0);
        @(negedge clk);
        check("ready_after", ready, 1);
    endtask

    initial begin
        logic [23:0] a[3];
        logic [31:0] e[3];
        logic [1:0]  s;
        logic [23:0] ra;
        logic        rw;
        int          w;

        req = 1'b0; we = 1'b0; size = 2'd0; addr = '0; wdata = '0; spi_miso = 1'b0;
        rst_n = 1'b1;
        flash_mem[32'h10] = 8'h13; flash_mem[32'h11] = 8'h05;
        flash_mem[32'h12] = 8'h10; flash_mem[32'h13] = 8'h00;
        ram_mem[5] = 8'hFF;

        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_sck", spi_sck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_cs", {spi_cs_flash_n, spi_cs_ram_n}, 2'b11);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_txn(1'b0, 2'd2, 24'h000010, 32'h0, 32'h00100513);
        run_txn(1'b1, 2'd1, 24'h800102, 32'hABCD1234, 32'h0);
        check("ram_102", ram_mem.exists(32'h102) ? ram_mem[32'h102] : 8'hxx, 8'h34);
        check("ram_103", ram_mem.exists(32'h103) ? ram_mem[32'h103] : 8'hxx, 8'h12);
        run_txn(1'b0, 2'd0, 24'h800005, 32'h0, 32'h000000FF);
        run_txn(1'b1, 2'd2, 24'h000100, 32'h12345678, 32'h0);
        run_txn(1'b0, 2'd3, 24'h800020, 32'h0, 32'h0);

        // Asynchronous reset part-way through a word read.
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 24'h000040;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        w = 0;
        while (mosi_bits.size() < 20 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("rst_reach_bit20", mosi_bits.size() >= 20, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cs", {spi_cs_flash_n, spi_cs_ram_n}, 2'b11);
        check("arst_sck", spi_sck, 0);
        check("arst_ready", ready, 1);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b0, 2'd0, 24'h800007, 32'h0, exp_read(24'h800007, 2'd0));

        // Three word reads with req held high throughout.
        for (int i = 0; i < 3; i++) begin
            a[i] = {1'($urandom), 23'($urandom_range(0, 63))};
            e[i] = exp_read(a[i], 2'd2);
        end
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; addr = a[0];
        fall0 = cs_falls;
        rise0 = sck_rises;
        @(posedge clk);
        finish_txn(1'b0, 2'd2, a[0], 32'h0, e[0], 1'b1, 2'd2, a[1]);
        @(posedge clk);
        finish_txn(1'b0, 2'd2, a[1], 32'h0, e[1], 1'b1, 2'd2, a[2]);
        @(posedge clk);
        finish_txn(1'b0, 2'd2, a[2], 32'h0, e[2], 1'b0, 2'd0, 24'h0);
        @(negedge clk);
        check("chain_ready_after", ready, 1);

        // Random mix of reads, writes and illegal requests.
        for (int i = 0; i < 40; i++) begin
            rw = 1'($urandom);
            s  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ra = {1'($urandom), 23'($urandom_range(0, 40))};
            if ($urandom_range(0, 9) == 0) ra[22:0] = 23'h7FFFFE;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_txn(rw, s, ra, $urandom, exp_read(ra, s));
        end

        check("protocol", proto, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
